// File: rtl/apb_spi_arbiter.sv
// Two-requester APB arbiter in front of a single SPI flash bridge: round-robin
// ownership, one registered transfer at a time, optional ACCESS timeout.

`ifndef P_ADDR_W
`define P_ADDR_W 32
`endif
`ifndef P_DATA_W
`define P_DATA_W 32
`endif
`ifndef P_STRB_W
`define P_STRB_W 4
`endif

// Handshake: a requester is pending while mN_psel=1 (penable ignored). It is
// finished in the single cycle where its mN_pready=1; that cycle also carries
// mN_prdata/mN_pslverr. The bridge side is plain APB: s_psel+s_penable held
// until s_pready=1 (or the timeout cuts it short).
module apb_spi_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 10
) (
  input  logic                  clk,
  input  logic                  resetn,

  input  logic [`P_ADDR_W-1:0]  m0_paddr,
  input  logic                  m0_psel,
  input  logic                  m0_penable,
  input  logic [2:0]            m0_pprot,
  input  logic                  m0_pwrite,
  input  logic [`P_DATA_W-1:0]  m0_pwdata,
  input  logic [`P_STRB_W-1:0]  m0_pstrb,
  output logic                  m0_pready,
  output logic [`P_DATA_W-1:0]  m0_prdata,
  output logic                  m0_pslverr,

  input  logic [`P_ADDR_W-1:0]  m1_paddr,
  input  logic                  m1_psel,
  input  logic                  m1_penable,
  input  logic [2:0]            m1_pprot,
  input  logic                  m1_pwrite,
  input  logic [`P_DATA_W-1:0]  m1_pwdata,
  input  logic [`P_STRB_W-1:0]  m1_pstrb,
  output logic                  m1_pready,
  output logic [`P_DATA_W-1:0]  m1_prdata,
  output logic                  m1_pslverr,

  output logic [`P_ADDR_W-1:0]  s_paddr,
  output logic                  s_psel,
  output logic                  s_penable,
  output logic [2:0]            s_pprot,
  output logic                  s_pwrite,
  output logic [`P_DATA_W-1:0]  s_pwdata,
  output logic [`P_STRB_W-1:0]  s_pstrb,
  input  logic                  s_pready,
  input  logic [`P_DATA_W-1:0]  s_prdata,
  input  logic                  s_pslverr,

  output logic [1:0]            grant,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_t;

  // TIMEOUT_CYCLES-1 must fit in CNT_W bits; the counter saturates at all-ones.
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? CNT_W'(0) : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_t state_q, state_d;

  logic                 owner_q;
  logic                 last_owner_q;
  logic                 pick;
  logic                 any_req;
  logic [CNT_W-1:0]     cnt_q;
  logic                 timeout_hit;
  logic                 owner_ready;
  logic                 owner_err;
  logic [`P_DATA_W-1:0] owner_rdata;

  logic [`P_ADDR_W-1:0] addr_q;
  logic [2:0]           prot_q;
  logic                 write_q;
  logic [`P_DATA_W-1:0] wdata_q;
  logic [`P_STRB_W-1:0] strb_q;

  assign any_req = m0_psel | m1_psel;

  // On a tie the requester that did not own the bus last time wins.
  always_comb begin
    pick = m1_psel;
    if (m0_psel && m1_psel) begin
      pick = ~last_owner_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (owner_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      addr_q       <= '0;
      prot_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      strb_q       <= '0;
    end else if (state_q == IDLE && any_req) begin
      owner_q      <= pick;
      last_owner_q <= pick;
      addr_q       <= pick ? m1_paddr  : m0_paddr;
      prot_q       <= pick ? m1_pprot  : m0_pprot;
      write_q      <= pick ? m1_pwrite : m0_pwrite;
      wdata_q      <= pick ? m1_pwdata : m0_pwdata;
      strb_q       <= pick ? m1_pstrb  : m0_pstrb;
    end
  end

  // Counts ACCESS cycles without s_pready; cleared during SETUP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (state_q == SETUP) begin
      cnt_q <= '0;
    end else if (state_q == ACCESS && !s_pready && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout_hit = TO_EN && (state_q == ACCESS) && (cnt_q == TO_LAST);

  // A real s_pready beats a coincident timeout.
  assign owner_ready = (state_q == ACCESS) && (s_pready || timeout_hit);
  assign owner_err   = s_pready ? s_pslverr : 1'b1;
  assign owner_rdata = s_pready ? s_prdata  : '0;

  assign m0_pready  = owner_ready && !owner_q;
  assign m1_pready  = owner_ready &&  owner_q;
  assign m0_prdata  = m0_pready ? owner_rdata : '0;
  assign m1_prdata  = m1_pready ? owner_rdata : '0;
  assign m0_pslverr = m0_pready && owner_err;
  assign m1_pslverr = m1_pready && owner_err;

  assign s_psel    = (state_q != IDLE);
  assign s_penable = (state_q == ACCESS);
  assign s_paddr   = addr_q;
  assign s_pprot   = prot_q;
  assign s_pwrite  = write_q;
  assign s_pwdata  = wdata_q;
  assign s_pstrb   = strb_q;

  assign grant     = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_spi_arbiter.sv
// Self-checking bench for apb_spi_arbiter: scenario tasks plus a completion
// scoreboard fed by the tasks and drained on every requester pready.

`ifndef P_ADDR_W
`define P_ADDR_W 32
`endif
`ifndef P_DATA_W
`define P_DATA_W 32
`endif
`ifndef P_STRB_W
`define P_STRB_W 4
`endif

module tb_apb_spi_arbiter;

  localparam int TO    = 8;
  localparam int EXP_W = 3 + `P_DATA_W;

  logic clk = 1'b0;
  logic resetn;

  logic [`P_ADDR_W-1:0] m0_paddr, m1_paddr, s_paddr;
  logic                 m0_psel, m0_penable, m0_pwrite, m0_pready, m0_pslverr;
  logic                 m1_psel, m1_penable, m1_pwrite, m1_pready, m1_pslverr;
  logic [2:0]           m0_pprot, m1_pprot, s_pprot;
  logic [`P_DATA_W-1:0] m0_pwdata, m1_pwdata, m0_prdata, m1_prdata;
  logic [`P_STRB_W-1:0] m0_pstrb, m1_pstrb, s_pstrb;
  logic                 s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
  logic [`P_DATA_W-1:0] s_pwdata, s_prdata;
  logic [1:0]           grant, dbg_state;
  logic                 busy;

  // Slave model knobs
  int                   slv_wait;
  bit                   slv_never;
  bit                   slv_err;
  logic [`P_DATA_W-1:0] slv_rdata;
  int                   acc_cnt = 0;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_got, mon_exp;

  apb_spi_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(10)) dut (
    .clk(clk), .resetn(resetn),
    .m0_paddr(m0_paddr), .m0_psel(m0_psel), .m0_penable(m0_penable),
    .m0_pprot(m0_pprot), .m0_pwrite(m0_pwrite), .m0_pwdata(m0_pwdata),
    .m0_pstrb(m0_pstrb), .m0_pready(m0_pready), .m0_prdata(m0_prdata),
    .m0_pslverr(m0_pslverr),
    .m1_paddr(m1_paddr), .m1_psel(m1_psel), .m1_penable(m1_penable),
    .m1_pprot(m1_pprot), .m1_pwrite(m1_pwrite), .m1_pwdata(m1_pwdata),
    .m1_pstrb(m1_pstrb), .m1_pready(m1_pready), .m1_prdata(m1_prdata),
    .m1_pslverr(m1_pslverr),
    .s_paddr(s_paddr), .s_psel(s_psel), .s_penable(s_penable),
    .s_pprot(s_pprot), .s_pwrite(s_pwrite), .s_pwdata(s_pwdata),
    .s_pstrb(s_pstrb), .s_pready(s_pready), .s_prdata(s_prdata),
    .s_pslverr(s_pslverr),
    .grant(grant), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Slave answers on ACCESS cycle number slv_wait (1-based) unless slv_never.
  always @(posedge clk) acc_cnt <= (s_psel && s_penable && !s_pready) ? acc_cnt + 1 : 0;
  assign s_pready  = s_psel && s_penable && !slv_never && (acc_cnt == slv_wait - 1);
  assign s_prdata  = slv_rdata;
  assign s_pslverr = slv_err;

  // Scoreboard: entry = {m1_pready, m0_pready, pslverr, prdata}
  always @(negedge clk) begin
    if (m0_pready || m1_pready) begin
      mon_got = {m1_pready, m0_pready, m0_pslverr | m1_pslverr, m0_prdata | m1_prdata};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pready got=%h exp=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL completion got=%h exp=%h", mon_got, mon_exp);
        end
      end
      done_cnt++;
    end
    checks++;
    if ((!m0_pready && (m0_prdata !== '0 || m0_pslverr !== 1'b0)) ||
        (!m1_pready && (m1_prdata !== '0 || m1_pslverr !== 1'b0))) begin
      failures++;
      $display("FAIL idle_resp_zero got=%h/%b %h/%b exp=0", m0_prdata, m0_pslverr,
               m1_prdata, m1_pslverr);
    end
  end

  // Driver tasks
  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_setup(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (s_psel && !s_penable) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(input int target, output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk); #1;
      if (done_cnt >= target) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    resetn  = 1'b0;
    m0_psel = 1'b1;
    idle_cycles(3);
    checks++;
    if ({s_psel, s_penable, grant, busy, dbg_state, m0_pready, m1_pready} !== 9'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0",
               {s_psel, s_penable, grant, busy, dbg_state, m0_pready, m1_pready});
    end
    checks++;
    if ({s_paddr, s_pwdata, s_pstrb, s_pwrite, s_pprot} !== '0) begin
      failures++;
      $display("FAIL reset_latched got=%h exp=0", {s_paddr, s_pwdata, s_pstrb});
    end
    m0_psel = 1'b0;
    resetn  = 1'b1;
    idle_cycles(2);
    checks++;
    if (busy !== 1'b0 || s_psel !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle got=%b%b exp=00", busy, s_psel);
    end
  endtask

  task automatic test_read_m0();
    bit ok; int lat; int base;
    base = done_cnt;
    slv_wait = 3; slv_never = 0; slv_err = 0; slv_rdata = 32'hDEADBEEF;
    exp_q.push_back({2'b01, 1'b0, 32'hDEADBEEF});
    m0_paddr = 32'h3000_0010; m0_pwrite = 1'b0; m0_pprot = 3'b100; m0_psel = 1'b1;
    wait_setup(ok);
    checks++;
    if (!ok || grant !== 2'b01 || busy !== 1'b1 || s_paddr !== 32'h3000_0010 ||
        s_pwrite !== 1'b0 || s_pprot !== 3'b100) begin
      failures++;
      $display("FAIL read_setup got=%b %b %h exp=1 01 30000010", ok, grant, s_paddr);
    end
    wait_done(base + 1, lat);
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL read_latency got=%0d exp=3", lat);
    end
    m0_psel = 1'b0;
    idle_cycles(1);
    checks++;
    if (s_psel !== 1'b0 || s_penable !== 1'b0 || grant !== 2'b00 || s_paddr !== 32'h3000_0010) begin
      failures++;
      $display("FAIL read_idle_hold got=%b%b %b %h exp=00 00 30000010", s_psel, s_penable, grant, s_paddr);
    end
  endtask

  task automatic test_back_to_back();
    int lat; int base;
    base = done_cnt;
    slv_wait = 1; slv_rdata = $urandom;
    exp_q.push_back({2'b01, 1'b0, slv_rdata});
    exp_q.push_back({2'b01, 1'b0, slv_rdata});
    m0_paddr = 32'h0000_0040; m0_psel = 1'b1;
    wait_done(base + 1, lat);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL min_latency got=%0d exp=2", lat);
    end
    idle_cycles(1);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle_gap got=%b exp=0", busy);
    end
    idle_cycles(1);
    checks++;
    if (!(s_psel && !s_penable) || grant !== 2'b01) begin
      failures++;
      $display("FAIL b2b_resetup got=%b%b %b exp=10 01", s_psel, s_penable, grant);
    end
    wait_done(base + 2, lat);
    m0_psel = 1'b0;
    checks++;
    if (lat < 0) begin
      failures++;
      $display("FAIL b2b_second got=%0d exp=done", lat);
    end
    idle_cycles(2);
  endtask

  task automatic test_psel_drop();
    bit ok; int lat; int base;
    base = done_cnt;
    slv_wait = 3; slv_err = 0; slv_rdata = 32'hCAFE_F00D;
    exp_q.push_back({2'b10, 1'b0, 32'hCAFE_F00D});
    m1_paddr = 32'h0000_0080; m1_pwrite = 1'b0; m1_psel = 1'b1;
    wait_setup(ok);
    m1_psel = 1'b0;
    wait_done(base + 1, lat);
    checks++;
    if (!ok || lat !== 3) begin
      failures++;
      $display("FAIL psel_drop got=%b/%0d exp=1/3", ok, lat);
    end
    idle_cycles(2);
  endtask

  task automatic test_write_m1();
    bit ok; int lat; int base;
    base = done_cnt;
    slv_wait = 2; slv_err = 1; slv_rdata = 32'h1111_2222;
    exp_q.push_back({2'b10, 1'b1, 32'h1111_2222});
    m1_paddr = 32'h3000_0100; m1_pwrite = 1'b1; m1_pwdata = 32'h1234_5678;
    m1_pstrb = 4'hF; m1_pprot = 3'b010; m1_penable = 1'b1; m1_psel = 1'b1;
    wait_setup(ok);
    checks++;
    if (!ok || grant !== 2'b10 || s_pwrite !== 1'b1 || s_pwdata !== 32'h1234_5678 ||
        s_pstrb !== 4'hF || s_pprot !== 3'b010 || s_paddr !== 32'h3000_0100) begin
      failures++;
      $display("FAIL write_setup got=%b %b %b %h %h exp=1 10 1 12345678 f", ok, grant,
               s_pwrite, s_pwdata, s_pstrb);
    end
    wait_done(base + 1, lat);
    m1_psel = 1'b0; m1_penable = 1'b0; slv_err = 0;
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL write_latency got=%0d exp=2", lat);
    end
    idle_cycles(2);
  endtask

  task automatic test_timeout();
    bit ok;
    slv_never = 1; slv_rdata = 32'hA5A5_A5A5; slv_err = 0;
    exp_q.push_back({2'b01, 1'b1, 32'h0});
    m0_paddr = 32'h0000_0200; m0_pwrite = 1'b0; m0_psel = 1'b1;
    wait_setup(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL timeout_setup got=0 exp=1");
    end
    for (int k = 1; k <= TO; k++) begin
      idle_cycles(1);
      checks++;
      if (m0_pready !== (k == TO)) begin
        failures++;
        $display("FAIL timeout_cycle_%0d got=%b exp=%b", k, m0_pready, (k == TO));
      end
    end
    m0_psel = 1'b0;
    idle_cycles(1);
    checks++;
    if (s_psel !== 1'b0 || s_penable !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_release got=%b%b%b exp=000", s_psel, s_penable, busy);
    end
    slv_never = 0;
    idle_cycles(1);
  endtask

  task automatic test_timeout_race();
    int lat; int base;
    base = done_cnt;
    slv_wait = TO; slv_err = 0; slv_rdata = 32'h0BAD_F00D;
    exp_q.push_back({2'b01, 1'b0, 32'h0BAD_F00D});
    m0_paddr = 32'h0000_0300; m0_psel = 1'b1;
    wait_done(base + 1, lat);
    m0_psel = 1'b0;
    checks++;
    if (lat !== TO + 1) begin
      failures++;
      $display("FAIL race_latency got=%0d exp=%0d", lat, TO + 1);
    end
    idle_cycles(2);
  endtask

  task automatic test_round_robin();
    bit ok; int lat; int base; int own;
    logic [`P_DATA_W-1:0] rr_data[4];
    logic [`P_ADDR_W-1:0] rr_addr[2];
    resetn = 1'b0;
    idle_cycles(1);
    resetn = 1'b1;
    base = done_cnt;
    slv_wait = 1; slv_err = 0;
    rr_addr[0] = 32'h0000_0100; rr_addr[1] = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      rr_data[i] = $urandom;
      exp_q.push_back({(i % 2 == 1), (i % 2 == 0), 1'b0, rr_data[i]});
    end
    m0_paddr = rr_addr[0]; m1_paddr = rr_addr[1]; m0_pwrite = 0; m1_pwrite = 0;
    m0_psel = 1'b1; m1_psel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      own = i % 2;
      wait_setup(ok);
      checks++;
      if (!ok || grant !== (own == 1 ? 2'b10 : 2'b01) || s_paddr !== rr_addr[own]) begin
        failures++;
        $display("FAIL rr_grant_%0d got=%b %h exp=m%0d %h", i, grant, s_paddr, own, rr_addr[own]);
      end
      slv_rdata = rr_data[i];
      wait_done(base + i + 1, lat);
      checks++;
      if (lat < 0) begin
        failures++;
        $display("FAIL rr_done_%0d got=timeout exp=done", i);
      end
    end
    m0_psel = 1'b0; m1_psel = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_reset_mid_access();
    bit ok; int lat; int base;
    slv_never = 1;
    m0_paddr = 32'h0000_0500; m0_psel = 1'b1;
    wait_setup(ok);
    idle_cycles(2);
    resetn = 1'b0;
    #1;
    checks++;
    if (!ok || s_psel !== 1'b0 || s_penable !== 1'b0 || busy !== 1'b0 ||
        grant !== 2'b00 || m0_pready !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%b%b%b %b %b exp=000 00 0", s_psel, s_penable, busy,
               grant, m0_pready);
    end
    m0_psel = 1'b0;
    idle_cycles(2);
    resetn = 1'b1;
    slv_never = 0; slv_wait = 1; slv_rdata = 32'h5555_AAAA;
    base = done_cnt;
    exp_q.push_back({2'b01, 1'b0, 32'h5555_AAAA});
    exp_q.push_back({2'b10, 1'b0, 32'h5555_AAAA});
    m0_psel = 1'b1; m1_psel = 1'b1;
    wait_setup(ok);
    checks++;
    if (!ok || grant !== 2'b01) begin
      failures++;
      $display("FAIL fresh_m0_priority got=%b exp=01", grant);
    end
    wait_done(base + 1, lat);
    wait_setup(ok);
    checks++;
    if (!ok || grant !== 2'b10) begin
      failures++;
      $display("FAIL fresh_m1_next got=%b exp=10", grant);
    end
    wait_done(base + 2, lat);
    m0_psel = 1'b0; m1_psel = 1'b0;
    checks++;
    if (lat < 0) begin
      failures++;
      $display("FAIL fresh_done got=timeout exp=done");
    end
    idle_cycles(2);
  endtask

  initial begin
    resetn = 1'b0;
    m0_paddr = '0; m0_psel = 0; m0_penable = 0; m0_pprot = '0; m0_pwrite = 0;
    m0_pwdata = '0; m0_pstrb = '0;
    m1_paddr = '0; m1_psel = 0; m1_penable = 0; m1_pprot = '0; m1_pwrite = 0;
    m1_pwdata = '0; m1_pstrb = '0;
    slv_wait = 1; slv_never = 0; slv_err = 0; slv_rdata = '0;
    #1;
    test_reset();
    test_read_m0();
    test_back_to_back();
    test_psel_drop();
    test_write_m1();
    test_timeout();
    test_timeout_race();
    test_round_robin();
    test_reset_mid_access();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drained got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_spi_arbiter.md
APB_SPI_ARBITER -- requirements
Module: apb_spi_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023, meaning max ACCESS cycles before forced error completion (0 = timeout disabled).
REQ-002 SHALL have parameter CNT_W, default 10, meaning timeout counter width.
REQ-003 SHALL have port clk  input  1  clock, all state updates on posedge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports mN_paddr/mN_psel/mN_penable/mN_pprot/mN_pwrite/mN_pwdata/mN_pstrb  input  `P_ADDR_W/1/1/3/1/`P_DATA_W/`P_STRB_W  APB requester N (N = 0 instruction fetch, N = 1 data).
REQ-006 SHALL have ports mN_pready/mN_prdata/mN_pslverr  output  1/`P_DATA_W/1  APB response to requester N.
REQ-007 SHALL have ports s_paddr/s_psel/s_penable/s_pprot/s_pwrite/s_pwdata/s_pstrb  output  same widths  APB to the shared SPI flash bridge.
REQ-008 SHALL have ports s_pready/s_prdata/s_pslverr  input  1/`P_DATA_W/1  response from the SPI flash bridge.
REQ-009 SHALL have ports grant  output  2  one-hot current owner (00 when idle); busy  output  1  transfer in progress.

Function
REQ-010 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE, state registered.
REQ-011 SHALL treat mN_psel=1 as a pending request from requester N, regardless of mN_penable.
REQ-012 IDLE: if any request pending, SHALL select owner, latch owner's paddr/pprot/pwrite/pwdata/pstrb into internal registers, go SETUP next cycle; else stay IDLE.
REQ-013 Arbitration SHALL be round-robin: single request wins; on simultaneous requests the requester not equal to last_owner wins.
REQ-014 last_owner SHALL update to the selected requester at each IDLE -> SETUP transition.
REQ-015 SETUP: s_psel=1, s_penable=0, s_* driven from latched registers; unconditionally -> ACCESS.
REQ-016 ACCESS: s_psel=1, s_penable=1; stay until s_pready=1 or timeout.
REQ-017 In ACCESS, owner's mN_pready SHALL equal s_pready combinationally; mN_prdata=s_prdata, mN_pslverr=s_pslverr in that cycle; then -> IDLE.
REQ-018 Non-owner mN_pready SHALL be 0 at all times; mN_prdata SHALL be 0 and mN_pslverr 0 whenever mN_pready=0.
REQ-019 s_psel, s_penable SHALL be 0 in IDLE; s_paddr/s_pwdata/etc. SHALL hold latched values.
REQ-020 Minimum latency: request seen in IDLE cycle T -> SETUP at T+1 -> ACCESS at T+2 -> mN_pready earliest at T+2.
REQ-021 Timeout counter SHALL clear on entering ACCESS, increment each ACCESS cycle with s_pready=0; on reaching TIMEOUT_CYCLES (nonzero) SHALL assert owner mN_pready=1, mN_pslverr=1, mN_prdata=0 that cycle, drop s_psel/s_penable next cycle, return IDLE.
REQ-022 Counter SHALL saturate, not wrap; TIMEOUT_CYCLES=0 SHALL never time out.
REQ-023 s_pready and timeout in same cycle: s_pready SHALL take priority (normal completion, slave's data and pslverr).
REQ-024 A requester that raises psel in the same cycle its previous transfer completes SHALL be re-arbitrated in IDLE next cycle like any other request; no back-to-back bypass of IDLE.
REQ-025 grant SHALL be one-hot of owner in SETUP/ACCESS, 00 in IDLE; busy = (state != IDLE).
REQ-026 Requester dropping psel mid-transfer (protocol violation) SHALL NOT abort the slave transfer; completion SHALL still run to IDLE.

Reset
REQ-027 resetn=0 SHALL asynchronously force state IDLE, last_owner=1 (m0 wins first tie), counter 0, latched registers 0.
REQ-028 During and after reset: s_psel=0, s_penable=0, all mN_pready=0, mN_pslverr=0, mN_prdata=0, grant=00, busy=0.
REQ-029 Reset asserted mid-ACCESS SHALL abandon the transfer with no pready to any requester.

Verification
REQ-030 m0 read 0x30000010, slave pready after 3 ACCESS cycles with prdata=0xDEADBEEF -> s_paddr=0x30000010, m0_pready high one cycle with 0xDEADBEEF, m1_pready stays 0.
REQ-031 m0, m1 both request from reset -> m0 served first, then m1; both held continuously -> grants alternate m0,m1,m0,m1.
REQ-032 TIMEOUT_CYCLES=8, slave never ready -> owner pready=1, pslverr=1, prdata=0 on 8th ACCESS cycle; s_psel low next cycle.
REQ-033 s_pready arrives on exactly timeout cycle -> normal completion, pslverr follows s_pslverr=0.
REQ-034 m1 write 0x12345678 strb 0xF -> s_pwrite=1, s_pwdata=0x12345678, s_pstrb=0xF; slave pslverr=1 -> m1_pslverr=1.
REQ-035 resetn pulsed low during ACCESS -> s_psel=0 immediately, no requester pready, next request starts fresh from IDLE with m0 priority.
